// File: rtl/fetch_pc_sequencer.sv
// Front-end next-PC selection: arbitrates commit/EX/ID redirects, BTB predictions
// and sequential advance, and sequences squash bubbles after back-end redirects.
module fetch_pc_sequencer #(
    parameter int                    PC_WIDTH      = 32,
    parameter int                    FETCH_WIDTH   = 4,
    parameter int                    SQUASH_CYCLES = 2,
    parameter logic [PC_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                recoverFlag_i,
    input  logic [PC_WIDTH-1:0] recoverPC_i,
    input  logic                flagRecoverEX_i,
    input  logic [PC_WIDTH-1:0] targetAddrEX_i,
    input  logic                flagRecoverID_i,
    input  logic [PC_WIDTH-1:0] targetAddrID_i,
    input  logic                btbTaken_i,
    input  logic [PC_WIDTH-1:0] btbTarget_i,
    input  logic                stall_i,
    input  logic                ctiQueueFull_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                fetchValid_o,
    output logic                flushFS1_o,
    output logic                flushFS2_o,
    output logic [1:0]          redirectSrc_o,
    output logic [15:0]         redirectCount_o
);

    typedef enum logic [1:0] {BOOT, RUN, SQUASH} state_t;

    localparam logic [PC_WIDTH-1:0] STEP        = PC_WIDTH'(FETCH_WIDTH * 8);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK  = ~PC_WIDTH'(7);
    localparam logic [3:0]          SQUASH_LOAD = 4'(SQUASH_CYCLES);

    state_t              state, state_next;
    logic [3:0]          bubble_cnt, bubble_next;
    logic [PC_WIDTH-1:0] pc_next;
    logic                hold;
    logic                back_redirect;
    logic                id_redirect;

    assign hold          = stall_i | ctiQueueFull_i;
    assign back_redirect = (state != BOOT) & (recoverFlag_i | flagRecoverEX_i);
    assign id_redirect   = (state == RUN) & flagRecoverID_i & ~recoverFlag_i & ~flagRecoverEX_i;

    // Back-end redirects are applied last so they override whatever the state chose.
    always_comb begin
        state_next    = state;
        bubble_next   = bubble_cnt;
        pc_next       = pc_o;
        fetchValid_o  = 1'b0;
        flushFS1_o    = 1'b0;
        flushFS2_o    = 1'b0;
        redirectSrc_o = 2'd0;

        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                fetchValid_o = ~hold & ~back_redirect;
                if (flagRecoverID_i)
                    pc_next = targetAddrID_i & ALIGN_MASK;
                else if (!hold)
                    pc_next = btbTaken_i ? (btbTarget_i & ALIGN_MASK) : (pc_o + STEP);
            end
            SQUASH: begin
                bubble_next = (bubble_cnt == 4'd0) ? 4'd0 : bubble_cnt - 4'd1;
                if (bubble_cnt <= 4'd1)
                    state_next = RUN;
            end
            default: state_next = BOOT;
        endcase

        if (back_redirect) begin
            flushFS1_o    = 1'b1;
            flushFS2_o    = 1'b1;
            bubble_next   = SQUASH_LOAD;
            state_next    = (SQUASH_CYCLES == 0) ? RUN : SQUASH;
            pc_next       = (recoverFlag_i ? recoverPC_i : targetAddrEX_i) & ALIGN_MASK;
            redirectSrc_o = recoverFlag_i ? 2'd3 : 2'd2;
        end else if (id_redirect) begin
            flushFS1_o    = 1'b1;
            redirectSrc_o = 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= BOOT;
            bubble_cnt      <= 4'd0;
            pc_o            <= RESET_PC;
            redirectCount_o <= 16'd0;
        end else begin
            state      <= state_next;
            bubble_cnt <= bubble_next;
            pc_o       <= pc_next;
            if ((back_redirect | id_redirect) && redirectCount_o != 16'hFFFF)
                redirectCount_o <= redirectCount_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed and randomized checks of fetch_pc_sequencer against a bubble-counting
// behavioural model of the fetch front end.
module tb_fetch_pc_sequencer;

    localparam int          SQ      = 2;
    localparam logic [31:0] RST_PC  = 32'h100;
    localparam logic [31:0] ALIGN   = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset;
    logic        recoverFlag_i, flagRecoverEX_i, flagRecoverID_i, btbTaken_i;
    logic [31:0] recoverPC_i, targetAddrEX_i, targetAddrID_i, btbTarget_i;
    logic        stall_i, ctiQueueFull_i;
    logic [31:0] pc_o;
    logic        fetchValid_o, flushFS1_o, flushFS2_o;
    logic [1:0]  redirectSrc_o;
    logic [15:0] redirectCount_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_pc;
    bit          m_boot;
    int          m_bub;
    int          m_cnt;
    int          cnt_before;

    always #5 clk = ~clk;

    fetch_pc_sequencer #(
        .PC_WIDTH(32), .FETCH_WIDTH(4), .SQUASH_CYCLES(SQ), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .reset(reset),
        .recoverFlag_i(recoverFlag_i), .recoverPC_i(recoverPC_i),
        .flagRecoverEX_i(flagRecoverEX_i), .targetAddrEX_i(targetAddrEX_i),
        .flagRecoverID_i(flagRecoverID_i), .targetAddrID_i(targetAddrID_i),
        .btbTaken_i(btbTaken_i), .btbTarget_i(btbTarget_i),
        .stall_i(stall_i), .ctiQueueFull_i(ctiQueueFull_i),
        .pc_o(pc_o), .fetchValid_o(fetchValid_o),
        .flushFS1_o(flushFS1_o), .flushFS2_o(flushFS2_o),
        .redirectSrc_o(redirectSrc_o), .redirectCount_o(redirectCount_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] rp, input logic e, input logic [31:0] et,
                         input logic i, input logic [31:0] it, input logic b, input logic [31:0] bt,
                         input logic s, input logic q);
        recoverFlag_i   = r; recoverPC_i    = rp;
        flagRecoverEX_i = e; targetAddrEX_i = et;
        flagRecoverID_i = i; targetAddrID_i = it;
        btbTaken_i      = b; btbTarget_i    = bt;
        stall_i         = s; ctiQueueFull_i = q;
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_boot = 1'b1; m_bub = 0; m_cnt = 0;
    endtask

    // One clock: compare outputs against the model, clock, then advance the model.
    task automatic step(input bit do_check);
        bit          running, big, id_ok, hold;
        logic [31:0] npc;
        logic [1:0]  src;
        #1;
        running = !m_boot && m_bub == 0;
        hold    = stall_i || ctiQueueFull_i;
        big     = !m_boot && (recoverFlag_i || flagRecoverEX_i);
        id_ok   = running && flagRecoverID_i && !big;
        npc     = m_pc;
        if (big)
            npc = (recoverFlag_i ? recoverPC_i : targetAddrEX_i) & ALIGN;
        else if (id_ok)
            npc = targetAddrID_i & ALIGN;
        else if (running && !hold)
            npc = btbTaken_i ? (btbTarget_i & ALIGN) : m_pc + 32'd32;
        src = big ? (recoverFlag_i ? 2'd3 : 2'd2) : (id_ok ? 2'd1 : 2'd0);
        if (do_check) begin
            check("pc", pc_o, m_pc);
            check("fetch_valid", 32'(fetchValid_o), 32'(running && !hold && !big));
            check("flush_fs1", 32'(flushFS1_o), 32'(big || id_ok));
            check("flush_fs2", 32'(flushFS2_o), 32'(big));
            check("redirect_src", 32'(redirectSrc_o), 32'(src));
            check("redirect_count", 32'(redirectCount_o), 32'(m_cnt));
        end
        @(posedge clk);
        m_pc = npc;
        if (m_boot)        m_boot = 1'b0;
        else if (big)      m_bub  = SQ;
        else if (m_bub > 0) m_bub--;
        if ((big || id_ok) && m_cnt < 65535) m_cnt++;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("reset_pc", pc_o, RST_PC);
        check("reset_valid", 32'(fetchValid_o), 32'd0);
        check("reset_count", 32'(redirectCount_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Boot cycle, then free-running sequential fetch.
        #1 check("boot_valid", 32'(fetchValid_o), 32'd0);
        step(1);
        step(1);
        check("seq_pc1", pc_o, 32'h120);
        step(1);
        check("seq_pc2", pc_o, 32'h140);

        // BTB prediction, then the same prediction under stall.
        drive(0, 0, 0, 0, 0, 0, 1, 32'h2004, 0, 0);
        step(1);
        check("btb_pc", pc_o, 32'h2000);
        drive(0, 0, 0, 0, 0, 0, 1, 32'h2004, 1, 0);
        #1 check("stall_valid", 32'(fetchValid_o), 32'd0);
        step(1);
        check("stall_pc", pc_o, 32'h2000);

        // EX redirect, an ID redirect ignored during the bubble, then recovery.
        drive(0, 0, 1, 32'h4000, 0, 0, 0, 0, 0, 0);
        #1;
        check("ex_flush1", 32'(flushFS1_o), 32'd1);
        check("ex_flush2", 32'(flushFS2_o), 32'd1);
        check("ex_src", 32'(redirectSrc_o), 32'd2);
        step(1);
        check("ex_pc", pc_o, 32'h4000);
        cnt_before = m_cnt;
        drive(0, 0, 0, 0, 1, 32'h5000, 1, 32'h6000, 0, 0);
        step(1);
        check("squash_id_pc", pc_o, 32'h4000);
        check("squash_id_count", 32'(redirectCount_o), 32'(cnt_before));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1);
        #1 check("post_bubble_valid", 32'(fetchValid_o), 32'd1);
        step(1);

        // Simultaneous commit, EX and ID requests: commit wins, counted once.
        cnt_before = m_cnt;
        drive(1, 32'h800, 1, 32'h900, 1, 32'h3000, 0, 0, 0, 0);
        #1 check("multi_src", 32'(redirectSrc_o), 32'd3);
        step(1);
        check("multi_pc", pc_o, 32'h800);
        check("multi_count", 32'(redirectCount_o), 32'(cnt_before + 1));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step(1);

        // ID redirect in RUN: front flush only, no bubble.
        drive(0, 0, 0, 0, 1, 32'h3000, 0, 0, 0, 0);
        #1;
        check("id_flush1", 32'(flushFS1_o), 32'd1);
        check("id_flush2", 32'(flushFS2_o), 32'd0);
        check("id_src", 32'(redirectSrc_o), 32'd1);
        step(1);
        check("id_pc", pc_o, 32'h3000);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("id_no_bubble", 32'(fetchValid_o), 32'd1);
        step(1);

        // Randomized mix of all request types.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 15) == 0, $urandom,
                  $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 3) == 0, $urandom,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
            step(1);
        end

        // Saturate the redirect counter with back-to-back ID redirects.
        for (int n = 0; n < 65540; n++) begin
            drive(0, 0, 0, 0, 1, $urandom, 0, 0, 0, 0);
            step(0);
        end
        check("sat_count", 32'(redirectCount_o), 32'hFFFF);
        step(1);

        // Asynchronous reset in the middle of a squash bubble.
        drive(0, 0, 1, 32'h7000, 0, 0, 0, 0, 0, 0);
        step(1);
        drive(1, 32'h8000, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_pc", pc_o, RST_PC);
        check("async_rst_count", 32'(redirectCount_o), 32'd0);
        check("async_rst_valid", 32'(fetchValid_o), 32'd0);
        check("async_rst_flush1", 32'(flushFS1_o), 32'd0);
        check("async_rst_src", 32'(redirectSrc_o), 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        model_reset();
        repeat (4) step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pc_sequencer.md
# fetch_pc_sequencer

Next-PC controller and redirect arbiter for the front end. Each cycle it picks the fetch PC that Fetch Stage 1 presents to the I-cache and BTB. Sources, in priority order: commit-time recovery, execute-stage mispredict, decode-stage (FS2) BTB-miss recovery, FS1 BTB prediction, sequential bundle advance. It also sequences squash bubbles after back-end redirects and gates fetch on back-end stall or CTI-queue full.

## Interface
Parameters:
- PC_WIDTH, 32, fetch PC width
- FETCH_WIDTH, 4, instructions per bundle; sequential advance is FETCH_WIDTH*8 bytes
- SQUASH_CYCLES, 2, fetch bubble length after commit or EX redirect, range 0..15
- RESET_PC, 0, PC loaded on reset; bits [2:0] are 0

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- recoverFlag_i  in  1  commit-time recovery request
- recoverPC_i  in  PC_WIDTH  commit recovery target
- flagRecoverEX_i  in  1  EX branch mispredict
- targetAddrEX_i  in  PC_WIDTH  EX corrected target
- flagRecoverID_i  in  1  FS2 recovery (BTB miss on taken CTI)
- targetAddrID_i  in  PC_WIDTH  FS2 target
- btbTaken_i  in  1  FS1 predicts taken CTI in current bundle
- btbTarget_i  in  PC_WIDTH  FS1 predicted target
- stall_i  in  1  back-end stall
- ctiQueueFull_i  in  1  CTI queue full
- pc_o  out  PC_WIDTH  current fetch PC (registered)
- fetchValid_o  out  1  FS1 issues a bundle this cycle
- flushFS1_o  out  1  squash FS1 contents
- flushFS2_o  out  1  squash FS2 contents
- redirectSrc_o  out  2  accepted redirect this cycle: 0 none/BTB/seq, 1 ID, 2 EX, 3 commit
- redirectCount_o  out  16  accepted commit+EX+ID redirects, saturating

## Operation
- States: BOOT, RUN, SQUASH. A 4-bit bubble counter is used in SQUASH.
- Reset (async): state=BOOT, pc_o=RESET_PC, counter=0, redirectCount_o=0. All other outputs are 0 while in reset.
- BOOT: fetchValid_o=0. Next state is RUN. PC holds.
- hold = stall_i | ctiQueueFull_i.
- RUN, next PC by priority:
  - recoverFlag_i: recoverPC_i
  - else flagRecoverEX_i: targetAddrEX_i
  - else flagRecoverID_i: targetAddrID_i
  - else hold: pc_o unchanged
  - else btbTaken_i: btbTarget_i
  - else pc_o + FETCH_WIDTH*8, wrapping modulo 2^PC_WIDTH
- All loaded targets have bits [2:0] forced to 0.
- fetchValid_o = (state==RUN) & ~hold & ~commit/EX redirect this cycle.
- Redirects are accepted regardless of hold. BTB and sequential advance are suppressed under hold.
- Commit or EX redirect (RUN or SQUASH):
  - flushFS1_o=1 and flushFS2_o=1 in the same cycle (combinational).
  - Counter loads SQUASH_CYCLES. If SQUASH_CYCLES=0 the next state is RUN; otherwise SQUASH.
- ID redirect in RUN: flushFS1_o=1, flushFS2_o=0, stays in RUN, no bubble.
- SQUASH:
  - fetchValid_o=0 and the counter decrements each cycle.
  - At counter==1 the next state is RUN.
  - A new commit/EX redirect reloads both PC and counter.
  - ID redirects and BTB predictions are ignored: no flush, not counted, src=0.
- Simultaneous requests: commit beats EX beats ID. Losing requests are dropped and not counted.
- redirectCount_o increments by 1 per accepted redirect (at most one per cycle) and sticks at 0xFFFF.
- redirectSrc_o is combinational and reflects only the accepted source.

## Timing
- Redirect-to-PC latency: 1 cycle. A request sampled at edge N makes pc_o equal the target after edge N.
- flush and redirectSrc outputs are combinational from the current-cycle inputs and state. No registered lag.
- Bubble: after a commit/EX redirect at edge N, fetchValid_o=0 for cycles N+1..N+SQUASH_CYCLES. It is 1 at N+SQUASH_CYCLES+1 if ~hold.
- fetchValid_o is also 0 in the redirect cycle itself.
- Reset asserted mid-SQUASH or mid-stall returns to BOOT immediately (asynchronous).
- After reset deasserts, the first fetchValid_o=1 is 2 cycles later (BOOT, then RUN).

## Test plan
- Reset then free-run, RESET_PC=0x100, no inputs -> fetchValid_o=0 in BOOT. pc_o then sequences 0x100, 0x120, 0x140 with fetchValid_o=1.
- btbTaken_i=1, btbTarget_i=0x2004 while hold=0 -> next pc_o=0x2000. Same request with stall_i=1 -> pc_o holds and fetchValid_o=0.
- flagRecoverEX_i=1 to 0x4000 with SQUASH_CYCLES=2:
  - Redirect cycle: flushFS1_o=flushFS2_o=1, src=2.
  - pc_o=0x4000, fetchValid_o low for 2 cycles, then high.
- recoverFlag_i to 0x800, flagRecoverEX_i to 0x900 and flagRecoverID_i same cycle -> pc_o=0x800, src=3, redirectCount_o +1 only.
- ID redirect to 0x3000 in RUN -> flushFS1_o=1, flushFS2_o=0, no bubble. ID redirect during SQUASH -> ignored, pc_o unchanged, count unchanged.
- 65540 forced ID redirects -> redirectCount_o saturates at 0xFFFF. Reset asserted mid-SQUASH -> pc_o=RESET_PC and count=0 immediately.
